regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
- 32 x 32-bit general-purpose register file for the pipelined CPU's decode stage.
- Directly upstream of the 32:1 operand read multiplexers: holds the register contents those multiplexers select from.
- Two combinational read ports with same-cycle write-through bypass; one synchronous write port driven by writeback.
- Per-register pending-write scoreboard that raises Stall when a decode-stage operand is still awaiting its producer.

Parameters:
- DW, 32, data width of each register.
- AW, 5, register address width; 2**AW registers.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous, active-high reset.
- Ra  input  AW  read address, port A.
- Rb  input  AW  read address, port B.
- Ra_use  input  1  port A operand is consumed by the decode-stage instruction.
- Rb_use  input  1  port B operand is consumed by the decode-stage instruction.
- Qa  output  DW  read data, port A.
- Qb  output  DW  read data, port B.
- Wr_en  input  1  writeback write enable.
- Wn  input  AW  writeback destination register.
- D  input  DW  writeback data.
- Iss_en  input  1  decode-stage instruction issues this cycle and will write Iss_rd.
- Iss_rd  input  AW  destination of the issuing instruction.
- Stall  output  1  decode must hold; the issue is not accepted.
- Pend_cnt  output  AW+1  number of registers currently marked pending.

Behaviour:
- Storage is R[0..31] plus pending bits P[0..31].
- Reset: on a rising Clk with Rst=1, all R are cleared to 0 and all P to 0. Rst overrides every write, issue and clear in the same cycle, including a reset in the middle of outstanding writes.
- After reset: Qa=Qb=0, Stall=0, Pend_cnt=0.
- Register 0: reads always return 0. Writes to register 0 are ignored. P[0] is never set.
- Read port A (combinational, zero latency):
  - Ra==0 -> Qa=0.
  - else if Wr_en and Wn==Ra -> Qa=D (write-through bypass).
  - else Qa=R[Ra].
- Read port B: identical rule using Rb and Qb.
- Write: on a rising Clk with Wr_en=1, Wn!=0 and Rst=0, R[Wn] <= D.
- Hazard detection (combinational):
  - hazA = Ra_use and Ra!=0 and P[Ra] and not (Wr_en and Wn==Ra).
  - hazB is the same expression for port B.
  - Stall = hazA or hazB.
  - A register whose writeback arrives in the current cycle is not a hazard, because the bypass supplies its data.
- Scoreboard update on a rising Clk with Rst=0, applied in this order:
  1. Clear: if Wr_en and Wn!=0, P[Wn] <= 0.
  2. Set: if Iss_en and not Stall and Iss_rd!=0, P[Iss_rd] <= 1.
  - Set wins when Wn==Iss_rd in the same cycle; a newer producer now owns the register.
- Iss_en while Stall=1 is ignored; the scoreboard is unchanged by that issue.
- Writeback to a register that is not pending: R is still updated, P stays 0, no error.
- Pend_cnt is the registered population count of P[31:1] and reflects the updated P one cycle after the edge.
- Maximum Pend_cnt is 31. The counter cannot wrap.
- No X propagation: every output is fully defined for all input values after the first reset.

Test Plan:
- Reset then read: assert Rst for one cycle; Ra=5, Rb=31 -> Qa=0, Qb=0, Stall=0, Pend_cnt=0.
- Write then read: Wr_en=1, Wn=3, D=0xDEADBEEF for one cycle, then Ra=3 -> Qa=0xDEADBEEF.
  - Wr_en=1, Wn=0, D=0x1234, then Ra=0 -> Qa=0.
- Bypass: R[7]=0x11. In the same cycle Wr_en=1, Wn=7, D=0x22, Ra=Rb=7 -> Qa=Qb=0x22 combinationally. The next cycle with Wr_en=0 -> 0x22.
- Load-use stall:
  - Iss_en=1, Iss_rd=9 -> Pend_cnt=1.
  - Next cycle Ra=9, Ra_use=1 -> Stall=1. With Ra_use=0 -> Stall=0.
  - Writeback Wn=9, D=0x55 with Ra=9 in the same cycle -> Stall=0, Qa=0x55.
  - Following cycle -> Pend_cnt=0.
- Simultaneous set/clear: P[4]=1; Wr_en=1, Wn=4, Iss_en=1, Iss_rd=4, Stall=0 -> P[4] stays 1 and Pend_cnt is unchanged. A stalled issue to register 10 -> P[10] stays 0.
- Reset mid-operation: mark registers 1..31 pending (Pend_cnt=31) and write R[2]=0xAA. Assert Rst together with Wr_en=1, Wn=2, D=0xBB -> R[2]=0, Pend_cnt=0, Stall=0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// 32 x 32-bit decode-stage register file with write-through bypass and a
// per-register pending-write scoreboard for load-use stall detection.
//
// Ports:
//   Clk, Rst           rising-edge clock, synchronous active-high reset
//   Ra, Rb             read addresses (combinational read, register 0 reads 0)
//   Ra_use, Rb_use     operand is consumed by the decode-stage instruction
//   Qa, Qb             read data, bypassed from D when writeback hits Ra/Rb
//   Wr_en, Wn, D       writeback port; clears the pending bit of Wn
//   Iss_en, Iss_rd     issuing instruction marks Iss_rd pending unless stalled
//   Stall              an in-use operand is still awaiting its producer
//   Pend_cnt           registered population count of pending registers
module regfile_scoreboard #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [AW-1:0] Ra,
    input  logic [AW-1:0] Rb,
    input  logic          Ra_use,
    input  logic          Rb_use,
    output logic [DW-1:0] Qa,
    output logic [DW-1:0] Qb,
    input  logic          Wr_en,
    input  logic [AW-1:0] Wn,
    input  logic [DW-1:0] D,
    input  logic          Iss_en,
    input  logic [AW-1:0] Iss_rd,
    output logic          Stall,
    output logic [AW:0]   Pend_cnt
);

    localparam int unsigned NREG = 1 << AW;
    localparam int unsigned CW   = AW + 1;

    logic [DW-1:0]   regs [NREG];
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_next;
    logic [CW-1:0]   cnt_next;
    logic            wr_live;
    logic            haz_a;
    logic            haz_b;

    // Writes to register 0 are dropped, so it keeps its reset value of zero.
    assign wr_live = Wr_en && (Wn != '0);

    // Register storage.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[Wn] <= D;
        end
    end

    // Read port A with same-cycle writeback bypass.
    always_comb begin
        if (Ra == '0) begin
            Qa = '0;
        end else if (Wr_en && (Wn == Ra)) begin
            Qa = D;
        end else begin
            Qa = regs[Ra];
        end
    end

    // Read port B with same-cycle writeback bypass.
    always_comb begin
        if (Rb == '0) begin
            Qb = '0;
        end else if (Wr_en && (Wn == Rb)) begin
            Qb = D;
        end else begin
            Qb = regs[Rb];
        end
    end

    // A pending operand whose writeback lands this cycle is served by the bypass.
    always_comb begin
        haz_a = Ra_use && (Ra != '0) && pend[Ra] && !(Wr_en && (Wn == Ra));
        haz_b = Rb_use && (Rb != '0) && pend[Rb] && !(Wr_en && (Wn == Rb));
        Stall = haz_a || haz_b;
    end

    // Scoreboard next state: clear on writeback, then set on accepted issue so a
    // newer producer to the same register keeps it pending.
    always_comb begin
        pend_next = pend;
        if (wr_live) begin
            pend_next[Wn] = 1'b0;
        end
        if (Iss_en && !Stall && (Iss_rd != '0)) begin
            pend_next[Iss_rd] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    // Population count of the updated scoreboard, excluding register 0.
    always_comb begin
        cnt_next = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            cnt_next = cnt_next + CW'(pend_next[i]);
        end
    end

    // Scoreboard and pending-count registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pend     <= '0;
            Pend_cnt <= '0;
        end else begin
            pend     <= pend_next;
            Pend_cnt <= cnt_next;
        end
    end

endmodule
